// File: rtl/obstacle_gen_if.sv
// ----------------------------------------------------------------------------
// obstacle_gen_if
//   Groups the game-state input and the packed obstacle field outputs of
//   obstacle_gen.
//
//   gamemode    : 2-bit game state (00 init, 01 playing, 10 paused, 11 over)
//   obstacle_x  : 10 slots x {x_left[9:0], x_right[9:0]}, slot i at [20i+:20]
//   obstacle_y  : 10 slots x {y_top[8:0], y_bottom[8:0]}, slot i at [18i+:18]
//   spawn_pulse : one-cycle strobe coincident with a slot being loaded
//
//   master : game side (drives gamemode, consumes the field)
//   slave  : obstacle_gen side
// ----------------------------------------------------------------------------
interface obstacle_gen_if;
    logic [1:0]   gamemode;
    logic [199:0] obstacle_x;
    logic [179:0] obstacle_y;
    logic         spawn_pulse;

    modport master (
        output gamemode,
        input  obstacle_x,
        input  obstacle_y,
        input  spawn_pulse
    );

    modport slave (
        input  gamemode,
        output obstacle_x,
        output obstacle_y,
        output spawn_pulse
    );
endinterface

// File: rtl/obstacle_gen.sv
// ----------------------------------------------------------------------------
// obstacle_gen
//   Maintains 10 obstacle slots. Obstacles spawn at the right edge with an
//   LFSR-chosen height and scroll left by a fixed step every TICK_DIV clocks
//   while playing. Cleared in init, frozen in pause and game over.
//
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     obs   : obstacle_gen_if.slave (gamemode in; obstacle_x, obstacle_y,
//             spawn_pulse out, all registered)
//
//   Optional build macro:
//     OBSTACLE_SPEED_RAMP_EN : scroll speed starts at SPEED and increases by
//                              one after every 8 successful spawns (max 15).
// ----------------------------------------------------------------------------
module obstacle_gen #(
    parameter int unsigned TICK_DIV  = 1666666,
    parameter int unsigned SPEED     = 2,
    parameter int unsigned SPAWN_GAP = 90,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned OBS_W     = 40,
    parameter int unsigned Y_MIN     = 100,
    parameter int unsigned OBS_H     = 80
) (
    input  logic          clk,
    input  logic          rst_n,
    obstacle_gen_if.slave obs
);

    localparam int unsigned N_SLOTS = 10;
    localparam int unsigned TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int unsigned GAP_W   = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SPAWN_GAP - 1);
    localparam logic [9:0]        SPAWN_XL  = 10'(SCREEN_W);
    localparam logic [9:0]        SPAWN_XR  = 10'(SCREEN_W + OBS_W);

    typedef enum logic [1:0] {
        MODE_INIT  = 2'b00,
        MODE_PLAY  = 2'b01,
        MODE_PAUSE = 2'b10,
        MODE_OVER  = 2'b11
    } mode_t;

    mode_t              mode;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [GAP_W-1:0]   spawn_q, spawn_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [199:0]       x_q, x_d;
    logic [179:0]       y_q, y_d;
    logic               pulse_q, pulse_d;

    logic [9:0]         spd;
    logic [9:0]         xl, xr;
    logic [8:0]         y_top_new, y_bot_new;
    logic               free_found;
    int unsigned        free_idx;

`ifdef OBSTACLE_SPEED_RAMP_EN
    logic [3:0]         speed_q, speed_d;
    logic [2:0]         tally_q, tally_d;
    assign spd = {6'b0, speed_q};
`else
    assign spd = 10'(SPEED);
`endif

    assign mode      = mode_t'(obs.gamemode);
    assign y_top_new = 9'(Y_MIN) + {1'b0, lfsr_q[7:0]};
    assign y_bot_new = y_top_new + 9'(OBS_H);

    assign obs.obstacle_x  = x_q;
    assign obs.obstacle_y  = y_q;
    assign obs.spawn_pulse = pulse_q;

    always_comb begin
        tick_d     = tick_q;
        spawn_d    = spawn_q;
        x_d        = x_q;
        y_d        = y_q;
        pulse_d    = 1'b0;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        xl         = '0;
        xr         = '0;
        free_found = 1'b0;
        free_idx   = 0;
`ifdef OBSTACLE_SPEED_RAMP_EN
        speed_d    = speed_q;
        tally_d    = tally_q;
`endif

        // Spawn target is chosen from the pre-step occupancy, so a slot
        // retired by this step's move is not reused until the next step.
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (!free_found && x_q[20*i +: 10] == '0) begin
                free_found = 1'b1;
                free_idx   = i;
            end
        end

        case (mode)
            MODE_INIT: begin
                tick_d  = '0;
                spawn_d = '0;
                x_d     = '0;
                y_d     = '0;
`ifdef OBSTACLE_SPEED_RAMP_EN
                speed_d = 4'(SPEED);
                tally_d = '0;
`endif
            end

            MODE_PLAY: begin
                if (tick_q != TICK_LAST) begin
                    tick_d = tick_q + 1'b1;
                end else begin
                    tick_d = '0;

                    for (int unsigned i = 0; i < N_SLOTS; i++) begin
                        xl = x_q[20*i+10 +: 10];
                        xr = x_q[20*i    +: 10];
                        if (xr != '0) begin
                            if (xr > spd) begin
                                x_d[20*i+10 +: 10] = (xl < spd) ? '0 : xl - spd;
                                x_d[20*i    +: 10] = xr - spd;
                            end else begin
                                x_d[20*i +: 20] = '0;
                                y_d[18*i +: 18] = '0;
                            end
                        end
                    end

                    // Target slot was inactive, so the move loop left it
                    // untouched; overwriting it here leaves it unmoved.
                    if (spawn_q == GAP_LAST) begin
                        spawn_d = '0;
                        if (free_found) begin
                            x_d[20*free_idx +: 20] = {SPAWN_XL, SPAWN_XR};
                            y_d[18*free_idx +: 18] = {y_top_new, y_bot_new};
                            pulse_d = 1'b1;
`ifdef OBSTACLE_SPEED_RAMP_EN
                            tally_d = tally_q + 1'b1;
                            if (tally_q == 3'd7 && speed_q != 4'd15)
                                speed_d = speed_q + 1'b1;
`endif
                        end
                    end else begin
                        spawn_d = spawn_q + 1'b1;
                    end
                end
            end

            MODE_PAUSE, MODE_OVER: begin
                // hold everything except the LFSR
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= '0;
            spawn_q <= '0;
            lfsr_q  <= 16'hACE1;
            x_q     <= '0;
            y_q     <= '0;
            pulse_q <= 1'b0;
`ifdef OBSTACLE_SPEED_RAMP_EN
            speed_q <= 4'(SPEED);
            tally_q <= '0;
`endif
        end else begin
            tick_q  <= tick_d;
            spawn_q <= spawn_d;
            lfsr_q  <= lfsr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pulse_q <= pulse_d;
`ifdef OBSTACLE_SPEED_RAMP_EN
            speed_q <= speed_d;
            tally_q <= tally_d;
`endif
        end
    end

endmodule

// File: doc/obstacle_gen.md
Name: obstacle_gen

Overview:
- Produces the packed obstacle field that game_logic consumes for collision detection and that the renderer draws.
- Holds 10 obstacle slots. Each slot has x_left/x_right (10-bit) and y_top/y_bottom (9-bit).
- Spawns obstacles at the right edge with an LFSR-chosen vertical position, then scrolls them left at a fixed rate.
- Follows game_logic's gamemode: clears on init, runs while playing, freezes on pause and on game over.

Parameters:
- TICK_DIV, 1666666, clock cycles per scroll step (100 MHz / 60 Hz).
- SPEED, 2, pixels subtracted from x per step (1..15).
- SPAWN_GAP, 90, steps between spawn attempts (>=1).
- SCREEN_W, 640, x_left of a newly spawned obstacle.
- OBS_W, 40, obstacle width; x_right = x_left + OBS_W.
- Y_MIN, 100, minimum y_top.
- OBS_H, 80, obstacle height; y_bottom = y_top + OBS_H.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- gamemode  input  2  game state: 00 init, 01 playing, 10 paused, 11 game over.
- obstacle_x  output  200  slot i at [20i+19:20i+10] = x_left, [20i+9:20i] = x_right.
- obstacle_y  output  180  slot i at [18i+17:18i+9] = y_top, [18i+8:18i] = y_bottom.
- spawn_pulse  output  1  one-cycle strobe in the cycle a slot is loaded.

Behaviour:
- Reset values:
  - obstacle_x = 0, obstacle_y = 0, spawn_pulse = 0.
  - tick_cnt = 0, spawn_cnt = 0, lfsr = 16'hACE1.
- Slot state: a slot is inactive iff its x_right == 0. All-zero fields mean an empty slot, and game_logic must not collide with it.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every clock in every gamemode, so spawn heights depend on when play starts.
- gamemode 00:
  - All slots are zeroed in the next cycle.
  - tick_cnt and spawn_cnt are cleared; spawn_pulse = 0.
- gamemode 10 and 11: tick_cnt, spawn_cnt and all slots hold their values. Outputs stay frozen and remain valid for collision and display.
- gamemode 01:
  - tick_cnt counts 0..TICK_DIV-1 and wraps. A step occurs in the cycle where tick_cnt == TICK_DIV-1.
  - Step, part 1 (move): every active slot with x_right > SPEED gets x_left and x_right each reduced by SPEED.
    - A saturating rule applies: if x_left < SPEED, x_left becomes 0.
    - A slot with x_right <= SPEED is retired, and all four of its fields go to 0.
  - Step, part 2 (spawn): spawn_cnt increments. When spawn_cnt == SPAWN_GAP-1, spawn_cnt resets to 0 and a spawn is attempted.
  - Spawn target: the lowest-index slot that was inactive at the start of the step. A slot retired in the same step is not reused until the next step.
  - Spawned values: x_left = SCREEN_W, x_right = SCREEN_W+OBS_W, y_top = Y_MIN + lfsr[7:0], y_bottom = y_top + OBS_H.
  - A newly spawned slot is not moved in its spawn step. spawn_pulse = 1 in that same cycle.
  - All 10 slots full: the spawn is dropped, spawn_pulse stays 0, and spawn_cnt still resets. There is no retry.
- Latency: a step's results appear on the outputs one clock after the step cycle, since all outputs are registered.
- Width rules:
  - Parameters must satisfy SCREEN_W+OBS_W <= 1023 and Y_MIN+255+OBS_H <= 511.
  - No other clamping is performed.
- Mode changes:
  - 01 to 10 to 01 resumes with tick_cnt and spawn_cnt unchanged.
  - 11 to 00 clears everything.
  - Asserting rst_n low mid-step returns all state to the reset values immediately, since reset is asynchronous.

Optional Feature:
- Macro: OBSTACLE_SPEED_RAMP_EN.
- Defined:
  - A 4-bit cur_speed register (reset value SPEED) replaces SPEED in the move rule.
  - cur_speed increments by 1 after every 8 successful spawns, saturating at 15.
  - gamemode 00 reloads cur_speed to SPEED and clears the spawn tally.
- Undefined: the speed is the constant SPEED. The register and the tally are not built.

Test Plan:
- Parameters for all scenarios: TICK_DIV=4, SPAWN_GAP=3, SPEED=2.
- Scenario 1: reset, then gamemode=01 for 12 clocks -> spawn_pulse high on clock 12, and on the next clock obstacle_x[19:0] = {640,680} and obstacle_y[17:0] = {100+lfsr[7:0], +80}.
- Scenario 2: continue for 4 more clocks (one step) -> slot0 = {638,678}. After 3 more steps slot1 spawns with {640,680} while slot0 = {632,672}.
- Scenario 3: preload slot0 x = {0,2} via force, then take one step -> slot0 retires to all zeros. The same-step spawn goes to slot1 and not slot0.
- Scenario 4: pause (gamemode=10) for 100 clocks -> obstacle_x and obstacle_y are bit-identical throughout. Resume with 01 -> the next step occurs after the remaining tick_cnt count.
- Scenario 5: fill all 10 slots, then reach the next spawn point -> no spawn_pulse and no slot changes apart from the move.
- Scenario 6: gamemode=11, then 00 -> the 11 phase holds the frozen outputs. The cycle after 00 shows obstacle_x=0 and obstacle_y=0. Async rst_n low mid-run clears all outputs with no clock edge.
